// File: rtl/play_state_pkg.sv
// rtl/play_state_pkg.sv - shared game constants, play-phase state encoding and helpers
package play_state_pkg;

  localparam int SEQ_LEN = 4;
  localparam int DATA_W  = 8;
  localparam int LED_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SHOW  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } play_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/play_state_led_decode.sv
// rtl/play_state_led_decode.sv - combinational 2-to-4 one-hot LED decoder
module led_decode
  import play_state_pkg::*;
(
  input  logic [1:0]       sel_i,
  output logic [LED_W-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/play_state.sv
// rtl/play_state.sv - plays pattern memory entries 0..SEQ_LEN-1 on LED/display outputs
module play_state
  import play_state_pkg::*;
#(
  parameter int SEQ_LEN     = play_state_pkg::SEQ_LEN,
  parameter int DATA_W      = play_state_pkg::DATA_W,
  parameter int SHOW_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  localparam int ADDR_W     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
  localparam int TIMER_W    = $clog2(max2(SHOW_CYCLES, GAP_CYCLES) + 1)
) (
  input  logic              clk,
  input  logic              rst_PLAY,
  input  logic              en_PLAY,
  input  logic [DATA_W-1:0] MEM_OUT,
  output logic              MEM_READ,
  output logic [ADDR_W-1:0] MEM_READ_ADDR,
  output logic [DATA_W-1:0] DISP_OUT,
  output logic [LED_W-1:0]  LED_OUT,
  output logic              complete_PLAY
);

  play_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               rd_q, rd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  disp_q, disp_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               done_q, done_d;
  logic [LED_W-1:0]   led_dec;

  led_decode u_led_decode (
    .sel_i    (MEM_OUT[1:0]),
    .onehot_o (led_dec)
  );

  // Every case below only moves when en_PLAY is high, so a low enable
  // freezes state, counters and outputs (a pending read strobe included).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    disp_d  = disp_q;
    led_d   = led_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (en_PLAY) begin
          state_d = S_FETCH;
          rd_d    = 1'b1;
          addr_d  = idx_q;
        end
      end
      S_FETCH: begin
        if (en_PLAY) begin
          state_d = S_WAIT;
          rd_d    = 1'b0;
        end
      end
      S_WAIT: begin
        if (en_PLAY) begin
          disp_d  = MEM_OUT;
          led_d   = led_dec;
          timer_d = '0;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (en_PLAY) begin
          if (timer_q == TIMER_W'(SHOW_CYCLES - 1)) begin
            disp_d  = '0;
            led_d   = '0;
            timer_d = '0;
            state_d = S_GAP;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (en_PLAY) begin
          if (timer_q == TIMER_W'(GAP_CYCLES - 1)) begin
            timer_d = '0;
            if (idx_q == ADDR_W'(SEQ_LEN - 1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 1'b1;
              addr_d  = idx_q + 1'b1;
              rd_d    = 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_PLAY) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      disp_q  <= '0;
      led_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      disp_q  <= disp_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign MEM_READ      = rd_q;
  assign MEM_READ_ADDR = addr_q;
  assign DISP_OUT      = disp_q;
  assign LED_OUT       = led_q;
  assign complete_PLAY = done_q;

endmodule

// File: tb/tb_play_state.sv
// tb/tb_play_state.sv - self-checking bench for play_state, default and 1/1 timing instances
module tb_play_state;

  localparam int N      = 4;
  localparam int SA     = 4;
  localparam int GA     = 2;
  localparam int SB     = 1;
  localparam int GB     = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] mem [N];
  logic [7:0] mem_out_a = 8'h00, mem_out_b = 8'h00;

  logic       rd_a, rd_b, done_a, done_b;
  logic [1:0] addr_a, addr_b;
  logic [7:0] disp_a, disp_b;
  logic [3:0] led_a, led_b;

  int errors = 0;
  int checks = 0;

  // reference progress per instance: started flag and count of active edges
  bit st_a = 0, st_b = 0;
  int k_a = 0, k_b = 0;

  always #5 clk = ~clk;

  play_state #(.SHOW_CYCLES(SA), .GAP_CYCLES(GA)) dut_a (
    .clk(clk), .rst_PLAY(rst), .en_PLAY(en), .MEM_OUT(mem_out_a),
    .MEM_READ(rd_a), .MEM_READ_ADDR(addr_a), .DISP_OUT(disp_a),
    .LED_OUT(led_a), .complete_PLAY(done_a)
  );

  play_state #(.SHOW_CYCLES(SB), .GAP_CYCLES(GB)) dut_b (
    .clk(clk), .rst_PLAY(rst), .en_PLAY(en), .MEM_OUT(mem_out_b),
    .MEM_READ(rd_b), .MEM_READ_ADDR(addr_b), .DISP_OUT(disp_b),
    .LED_OUT(led_b), .complete_PLAY(done_b)
  );

  // synchronous-read pattern memory: data valid the cycle after the strobe
  always @(posedge clk) begin
    if (rd_a) mem_out_a <= mem[addr_a];
    if (rd_b) mem_out_b <= mem[addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic advance(inout bit st, inout int k, input int s, input int g);
    int total;
    total = N * (2 + s + g);
    if (rst) begin
      st = 0;
      k  = 0;
    end else if (!st) begin
      if (en) begin
        st = 1;
        k  = 1;
      end
    end else if (en && (k - 1) < total) begin
      k++;
    end
  endtask

  // Entry e occupies P edges: fetch, wait, s show cycles, g gap cycles.
  task automatic expect_out(input bit st, input int k, input int s, input int g,
                            output logic rd, output logic [1:0] addr,
                            output logic [7:0] disp, output logic [3:0] led,
                            output logic done);
    int p, j, e, ph;
    logic [7:0] v;
    rd = 0; addr = 0; disp = 0; led = 0; done = 0;
    if (st) begin
      p = 2 + s + g;
      j = k - 1;
      if (j >= N * p) begin
        done = 1;
      end else begin
        e  = j / p;
        ph = j % p;
        addr = 2'(e);
        rd = (ph == 0);
        if (ph >= 2 && ph < 2 + s) begin
          v    = mem[e];
          disp = v;
          led  = 4'b0001 << v[1:0];
        end
      end
    end
  endtask

  task automatic check_all();
    logic rd, done;
    logic [1:0] addr;
    logic [7:0] disp;
    logic [3:0] led;
    expect_out(st_a, k_a, SA, GA, rd, addr, disp, led, done);
    chk("a_read", 32'(rd_a), 32'(rd));
    if (rd) chk("a_addr", 32'(addr_a), 32'(addr));
    chk("a_disp", 32'(disp_a), 32'(disp));
    chk("a_led", 32'(led_a), 32'(led));
    chk("a_done", 32'(done_a), 32'(done));
    expect_out(st_b, k_b, SB, GB, rd, addr, disp, led, done);
    chk("b_read", 32'(rd_b), 32'(rd));
    if (rd) chk("b_addr", 32'(addr_b), 32'(addr));
    chk("b_disp", 32'(disp_b), 32'(disp));
    chk("b_led", 32'(led_b), 32'(led));
    chk("b_done", 32'(done_b), 32'(done));
  endtask

  task automatic cyc();
    @(posedge clk);
    advance(st_a, k_a, SA, GA);
    advance(st_b, k_b, SB, GB);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1; en = 0;
    cyc();
    rst = 0;
  endtask

  int da, db;

  initial begin
    mem[0] = 8'hA1; mem[1] = 8'h42; mem[2] = 8'h13; mem[3] = 8'hF0;

    // reset, then enable held low: nothing may start
    rst = 1; en = 0;
    cyc(); cyc();
    rst = 0;
    for (int n = 0; n < 10; n++) cyc();

    // full default sequence; completion edge measured from first enabled edge
    en = 1; da = -1; db = -1;
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (da < 0 && done_a) da = n;
      if (db < 0 && done_b) db = n;
    end
    chk("done_edge_a", 32'(da), 32'd32);
    chk("done_edge_b", 32'(db), 32'd16);

    // after completion: toggle enable and scramble memory, must stay done and dark
    for (int n = 0; n < 12; n++) begin
      en = n[0];
      mem[n % N] = 8'($urandom);
      cyc();
    end
    mem[0] = 8'hA1; mem[1] = 8'h42; mem[2] = 8'h13; mem[3] = 8'hF0;

    // freeze for 5 cycles while entry 1 is shown
    do_reset();
    da = -1; db = -1;
    for (int n = 0; n < 45; n++) begin
      en = !(n >= 11 && n <= 15);
      cyc();
      if (n >= 11 && n <= 15) begin
        chk("frz_disp", 32'(disp_a), 32'h42);
        chk("frz_led", 32'(led_a), 32'h4);
      end
      if (da < 0 && done_a) da = n;
      if (db < 0 && done_b) db = n;
    end
    chk("frz_done_a", 32'(da), 32'd37);
    chk("frz_done_b", 32'(db), 32'd21);

    // reset during entry 2's gap, then restart from address 0
    do_reset();
    en = 1;
    for (int n = 0; n < 23; n++) cyc();
    rst = 1;
    cyc();
    chk("rst_read", 32'(rd_a), 32'd0);
    chk("rst_disp", 32'(disp_a), 32'd0);
    chk("rst_led", 32'(led_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    rst = 0;
    cyc();
    chk("restart_read", 32'(rd_a), 32'd1);
    chk("restart_addr", 32'(addr_a), 32'd0);
    for (int n = 0; n < 40; n++) cyc();

    // randomized memory contents and enable pattern
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
      for (int n = 0; n < 90; n++) begin
        en = ($urandom_range(0, 3) != 0);
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/play_state.md
Name: play_state

Overview:
- Read-side counterpart of the idle-phase sequence writer.
- The writer fills a 4-entry pattern memory with LFSR values; this block reads entries 0..3 back in order.
- Each entry is shown on the LED/display outputs for a fixed time, with a blank gap between entries, then the block signals completion.
- Sits between the pattern memory and the player-facing LEDs; enabled by the top-level game FSM after idle completes.

Parameters:
- SEQ_LEN, 4: number of memory entries played. Address width is $clog2(SEQ_LEN), which is 2 at the default.
- DATA_W, 8: memory word width.
- SHOW_CYCLES, 4: cycles each entry is displayed. Must be ≥1.
- GAP_CYCLES, 2: blank cycles after each entry. Must be ≥1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_PLAY  in  1  synchronous, active-high reset.
- en_PLAY  in  1  run enable. When low, the block holds state and all counters.
- MEM_OUT  in  DATA_W  memory read data. Valid in the cycle after MEM_READ is high.
- MEM_READ  out  1  read strobe, one cycle per entry.
- MEM_READ_ADDR  out  2  entry index being read.
- DISP_OUT  out  DATA_W  latched entry value. Zero when not showing.
- LED_OUT  out  4  one-hot decode of the shown entry's MEM_OUT[1:0]. Zero when not showing.
- complete_PLAY  out  1  sticky done flag.

Behaviour:
- Reset (rst_PLAY=1, takes priority over everything, including mid-sequence):
  - state=S_IDLE, idx=0, timer=0.
  - MEM_READ=0, MEM_READ_ADDR=0, DISP_OUT=0, LED_OUT=0, complete_PLAY=0.
- All outputs are registered.
- States: S_IDLE, S_FETCH, S_WAIT, S_SHOW, S_GAP, S_DONE.
- S_IDLE: when en_PLAY=1, go to S_FETCH.
- S_FETCH (1 cycle): MEM_READ=1, MEM_READ_ADDR=idx. Next state S_WAIT.
- S_WAIT (1 cycle): MEM_READ=0.
  - At the exiting edge, capture MEM_OUT into DISP_OUT.
  - LED_OUT = 1 << MEM_OUT[1:0].
  - timer=0. Next state S_SHOW.
- S_SHOW: timer increments each cycle. When timer == SHOW_CYCLES-1:
  - clear DISP_OUT and LED_OUT;
  - timer=0;
  - next state S_GAP.
- S_GAP: timer increments each cycle. When timer == GAP_CYCLES-1:
  - if idx == SEQ_LEN-1, go to S_DONE;
  - otherwise idx=idx+1 and go to S_FETCH.
  - idx never wraps mid-sequence.
- S_DONE: complete_PLAY=1 and held until rst_PLAY. Outputs are blank and MEM_READ=0. en_PLAY is ignored.
- Period per entry: 2 + SHOW_CYCLES + GAP_CYCLES cycles.
  - With defaults, en_PLAY first sampled high at edge 0 makes complete_PLAY visible after edge 32.
  - The first LED appears after edge 2.
- en_PLAY=0 in any non-IDLE, non-DONE state freezes state, timer, idx and all outputs.
  - A MEM_READ high in S_FETCH stays high while frozen. Memory tolerates repeated reads of the same address.
- MEM_OUT[7:2] affects DISP_OUT only; LED_OUT uses bits [1:0].
- Timer width is $clog2(max(SHOW_CYCLES, GAP_CYCLES)+1); no overflow is possible.

Decomposition:
- Shared game package holds:
  - state encoding localparams for this block;
  - the LED one-hot width (4);
  - the common pattern-memory constants (SEQ_LEN, DATA_W), shared with the idle-phase writer.
- One natural sub-module, led_decode: combinational 2-to-4 one-hot decoder, reusable by the player-input checker. Its result is registered in play_state.

Test Plan:
1. Reset, then en_PLAY=1 with memory {0xA1, 0x42, 0x13, 0xF0}:
   - MEM_READ pulses with addr 0,1,2,3 at edges 0, 8, 16, 24;
   - DISP_OUT shows A1, 42, 13, F0, each for 4 cycles;
   - LED_OUT shows 0010, 0100, 1000, 0001;
   - complete_PLAY=1 after edge 32.
2. Drop en_PLAY for 5 cycles during entry 1's S_SHOW (DISP_OUT=0x42):
   - DISP_OUT and LED_OUT hold 0x42 / 0100;
   - completion is delayed by exactly 5 cycles (edge 37).
3. Assert rst_PLAY during entry 2's S_GAP:
   - next cycle all outputs are 0 and state is S_IDLE;
   - re-enable restarts from addr 0.
4. After completion, toggle en_PLAY and change memory contents: complete_PLAY stays 1, MEM_READ stays 0, LEDs stay dark.
5. Parameter override SHOW_CYCLES=1, GAP_CYCLES=1: period is 4 cycles; completion after edge 16; no off-by-one in timer compare.
6. Hold en_PLAY=0 from reset for 10 cycles: block stays in S_IDLE, MEM_READ never asserts, all outputs are 0.
